// File: rtl/uc_pkg.sv
// Shared types and literal-decode helpers for the unit-clause arbiter.
// Literals arrive sign-extended to int so the helpers work for any LIT_W.
package uc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      CONFLICT = 2'd2
   } uc_arb_state_t;

   // Variable number: magnitude of the literal.
   function automatic int lit_var(input int lit);
      return (lit < 32'sd0) ? -lit : lit;
   endfunction

   // Polarity: 1 for a negated literal.
   function automatic logic lit_pol(input int lit);
      return (lit < 32'sd0);
   endfunction

   // Zero and the most negative code have no variable behind them.
   function automatic logic lit_legal(input int lit, input int lit_w);
      return (lit != 32'sd0) && (lit != -(32'sd1 <<< (lit_w - 1)));
   endfunction

endpackage

// File: rtl/uc_fifo.sv
// Synchronous broadcast FIFO; head is read straight out of the register array.
// Flush empties the queue without touching the storage contents.
module uc_fifo #(
   parameter int LIT_W  = 8,
   parameter int QDEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [LIT_W-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [LIT_W-1:0] o_head
);

   localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   logic [LIT_W-1:0] r_mem [QDEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (AW+1)'(QDEPTH));
   assign o_empty   = (r_count == (AW+1)'(0));
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (w_do_push && !rst && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end else begin
         r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally at QDEPTH.
   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= AW'(0);
         r_rd_ptr <= AW'(0);
         r_count  <= (AW+1)'(0);
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uc_rr_arbiter.sv
// Unit-clause arbiter: loads initial UCs from memory, round-robins implied
// UCs from the engines, dedups/conflict-checks them against a per-variable
// assignment table and broadcasts accepted UCs through uc_fifo.
module uc_rr_arbiter
   import uc_pkg::*;
#(
   parameter int NUM_ENG = 4,
   parameter int LIT_W   = 8,
   parameter int QDEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     mem_valid,
   input  logic [LIT_W-1:0]         mem_lit,
   input  logic                     mem_done,
   output logic                     mem_ready,
   input  logic [NUM_ENG-1:0]       eng_valid,
   input  logic [NUM_ENG*LIT_W-1:0] eng_lit,
   output logic [NUM_ENG-1:0]       eng_ready,
   output logic                     out_valid,
   output logic [LIT_W-1:0]         out_lit,
   input  logic                     out_ready,
   output logic                     conflict,
   output logic [LIT_W-1:0]         conflict_lit,
   output logic                     quiescent,
   output logic [LIT_W-1:0]         n_assigned
);

   localparam int VAR_W   = LIT_W - 1;
   localparam int VAR_NUM = 2 ** VAR_W;
   localparam int IDX_W   = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

   uc_arb_state_t      r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [VAR_NUM-1:0] r_pos;
   logic [VAR_NUM-1:0] r_neg;
   logic [LIT_W-1:0]   r_conflict_lit;
   logic               r_conflict;
   logic [LIT_W-1:0]   r_n_assigned;

   int                 w_pick;
   logic               w_grant;
   logic [LIT_W-1:0]   w_eng_lit;
   logic [LIT_W-1:0]   w_cand_lit;
   logic               w_cand_valid;
   int                 w_lit_int;
   logic [VAR_W-1:0]   w_var;
   logic               w_pol;
   logic               w_legal;
   logic               w_opp;
   logic               w_same;
   logic               w_push;
   logic               w_conf;
   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_flush;
   logic [LIT_W-1:0]   w_head;

   // First requesting channel at or after ptr, scanning cyclically; -1 if none.
   function automatic int rr_pick(input logic [NUM_ENG-1:0] req, input int ptr);
      int pick;
      pick = -1;
      for (int k = 0; k < NUM_ENG; k++) begin
         for (int i = 0; i < NUM_ENG; i++) begin
            if ((pick < 0) && (i == ((ptr + k) % NUM_ENG)) && req[i]) begin
               pick = i;
            end
         end
      end
      return pick;
   endfunction

   // Handshake, grant selection and accept/dedup/conflict decision.
   always_comb begin
      w_pick    = rr_pick(eng_valid, int'(r_ptr));
      w_grant   = (r_state == RUN) && !w_full && (w_pick >= 0) && !rst && !clear;
      mem_ready = (r_state == IDLE) && !w_full && !rst && !clear;
      eng_ready = {NUM_ENG{1'b0}};
      w_eng_lit = {LIT_W{1'b0}};
      for (int i = 0; i < NUM_ENG; i++) begin
         if (i == w_pick) begin
            w_eng_lit    = eng_lit[i*LIT_W +: LIT_W];
            eng_ready[i] = w_grant;
         end else begin
            w_eng_lit    = w_eng_lit;
         end
      end
      if (r_state == IDLE) begin
         w_cand_valid = mem_valid && mem_ready;
         w_cand_lit   = mem_lit;
      end else begin
         w_cand_valid = w_grant;
         w_cand_lit   = w_eng_lit;
      end
      w_lit_int = int'($signed(w_cand_lit));
      w_var     = VAR_W'(lit_var(w_lit_int));
      w_pol     = lit_pol(w_lit_int);
      w_legal   = lit_legal(w_lit_int, LIT_W);
      w_opp     = w_pol ? r_pos[w_var] : r_neg[w_var];
      w_same    = w_pol ? r_neg[w_var] : r_pos[w_var];
      w_push    = w_cand_valid && w_legal && !w_opp && !w_same;
      w_conf    = w_cand_valid && w_legal && w_opp;
   end

   // Broadcast side and idle indication.
   always_comb begin
      out_valid = !w_empty && (r_state != CONFLICT);
      w_pop     = out_valid && out_ready;
      w_flush   = clear || w_conf || (r_state == CONFLICT);
      if (out_valid) begin
         out_lit = w_head;
      end else begin
         out_lit = {LIT_W{1'b0}};
      end
      quiescent = (r_state == RUN) && w_empty && (eng_valid == {NUM_ENG{1'b0}}) && !w_pop;
   end

   uc_fifo #(
      .LIT_W  (LIT_W),
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (w_flush),
      .i_push  (w_push),
      .i_data  (w_cand_lit),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   // Phase FSM, rr pointer, assignment table and conflict/count registers.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_state        <= IDLE;
         r_ptr          <= IDX_W'(0);
         r_pos          <= {VAR_NUM{1'b0}};
         r_neg          <= {VAR_NUM{1'b0}};
         r_conflict     <= 1'b0;
         r_conflict_lit <= {LIT_W{1'b0}};
         r_n_assigned   <= {LIT_W{1'b0}};
      end else begin
         case (r_state)
            IDLE: begin
               if (w_conf) begin
                  r_state <= CONFLICT;
               end else if (mem_done) begin
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               if (w_conf) begin
                  r_state <= CONFLICT;
               end else begin
                  r_state <= RUN;
               end
            end
            CONFLICT: r_state <= CONFLICT;
            default:  r_state <= IDLE;
         endcase
         if (w_grant) begin
            r_ptr <= IDX_W'((w_pick + 1) % NUM_ENG);
         end else begin
            r_ptr <= r_ptr;
         end
         if (w_push && w_pol) begin
            r_neg[w_var] <= 1'b1;
         end else if (w_push) begin
            r_pos[w_var] <= 1'b1;
         end else begin
            r_pos <= r_pos;
         end
         if (w_conf) begin
            r_conflict     <= 1'b1;
            r_conflict_lit <= w_cand_lit;
         end else begin
            r_conflict     <= r_conflict;
            r_conflict_lit <= r_conflict_lit;
         end
         if (w_push && (r_n_assigned != LIT_W'(VAR_NUM - 1))) begin
            r_n_assigned <= r_n_assigned + LIT_W'(1);
         end else begin
            r_n_assigned <= r_n_assigned;
         end
      end
   end

   assign conflict     = r_conflict;
   assign conflict_lit = r_conflict_lit;
   assign n_assigned   = r_n_assigned;

endmodule

// File: tb/tb_uc_rr_arbiter.sv
// Directed bench for uc_rr_arbiter (NUM_ENG=4, LIT_W=8, QDEPTH=4).
module tb_uc_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst, clear, mem_valid, mem_done, out_ready;
   logic [7:0]  mem_lit;
   logic        mem_ready;
   logic [3:0]  eng_valid, eng_ready;
   logic [31:0] eng_lit;
   logic        out_valid, conflict, quiescent;
   logic [7:0]  out_lit, conflict_lit, n_assigned;
   int          checks = 0;
   int          errors = 0;

   uc_rr_arbiter #(.NUM_ENG(4), .LIT_W(8), .QDEPTH(4)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .mem_valid(mem_valid), .mem_lit(mem_lit), .mem_done(mem_done), .mem_ready(mem_ready),
      .eng_valid(eng_valid), .eng_lit(eng_lit), .eng_ready(eng_ready),
      .out_valid(out_valid), .out_lit(out_lit), .out_ready(out_ready),
      .conflict(conflict), .conflict_lit(conflict_lit),
      .quiescent(quiescent), .n_assigned(n_assigned)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; clear = 1'b0; mem_valid = 1'b0; mem_lit = 8'h00; mem_done = 1'b0;
      eng_valid = 4'b0000; eng_lit = 32'h0; out_ready = 1'b0;
      step(); step();
      checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b want 0", conflict); end
      checks++; if (conflict_lit !== 8'h00) begin errors++; $display("FAIL reset_conflict_lit: got %h want 00", conflict_lit); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
      checks++; if (eng_ready !== 4'b0000) begin errors++; $display("FAIL reset_eng_ready: got %b want 0000", eng_ready); end
      checks++; if (quiescent !== 1'b0) begin errors++; $display("FAIL reset_quiescent: got %b want 0", quiescent); end
      checks++; if (n_assigned !== 8'h00) begin errors++; $display("FAIL reset_n_assigned: got %0d want 0", n_assigned); end
      rst = 1'b0;
      #1;
   endtask

   task automatic test_load();
      mem_valid = 1'b1; mem_lit = 8'd3;
      #1;
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL load_mem_ready: got %b want 1", mem_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_lit !== 8'd3) begin errors++; $display("FAIL load_latency: got v=%b lit=%h want v=1 lit=03", out_valid, out_lit); end
      mem_lit = 8'hFB;
      step();
      mem_lit = 8'd7; mem_done = 1'b1;
      step();
      mem_valid = 1'b0; mem_done = 1'b0;
      #1;
      checks++; if (n_assigned !== 8'd3) begin errors++; $display("FAIL load_n_assigned: got %0d want 3", n_assigned); end
      checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL load_run_mem_ready: got %b want 0", mem_ready); end
      checks++; if (quiescent !== 1'b0) begin errors++; $display("FAIL load_not_quiescent: got %b want 0", quiescent); end
      out_ready = 1'b1;
      #1;
      checks++; if (out_lit !== 8'd3) begin errors++; $display("FAIL load_out0: got %h want 03", out_lit); end
      step();
      checks++; if (out_valid !== 1'b1 || out_lit !== 8'hFB) begin errors++; $display("FAIL load_out1: got v=%b lit=%h want v=1 lit=fb", out_valid, out_lit); end
      step();
      checks++; if (out_valid !== 1'b1 || out_lit !== 8'd7) begin errors++; $display("FAIL load_out2: got v=%b lit=%h want v=1 lit=07", out_valid, out_lit); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_drained: got %b want 0", out_valid); end
      checks++; if (quiescent !== 1'b1) begin errors++; $display("FAIL load_quiescent: got %b want 1", quiescent); end
   endtask

   task automatic test_dedup();
      out_ready = 1'b0;
      do_clear();
      checks++; if (n_assigned !== 8'd0) begin errors++; $display("FAIL dedup_clear_n: got %0d want 0", n_assigned); end
      mem_valid = 1'b1; mem_lit = 8'd4; mem_done = 1'b1;
      step();
      mem_valid = 1'b0; mem_done = 1'b0;
      eng_valid = 4'b0001; eng_lit = 32'h0000_0004;
      #1;
      checks++; if (eng_ready !== 4'b0001) begin errors++; $display("FAIL dedup_grant: got %b want 0001", eng_ready); end
      step();
      eng_valid = 4'b0000;
      #1;
      checks++; if (n_assigned !== 8'd1) begin errors++; $display("FAIL dedup_n: got %0d want 1", n_assigned); end
      out_ready = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b1 || out_lit !== 8'd4) begin errors++; $display("FAIL dedup_out: got v=%b lit=%h want v=1 lit=04", out_valid, out_lit); end
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dedup_once: got %b want 0", out_valid); end
   endtask

   task automatic test_conflict();
      out_ready = 1'b0;
      do_clear();
      mem_valid = 1'b1; mem_lit = 8'd6; mem_done = 1'b1;
      step();
      mem_valid = 1'b0; mem_done = 1'b0;
      eng_valid = 4'b0100; eng_lit = 32'h00FA_0000;
      #1;
      checks++; if (eng_ready !== 4'b0100 || conflict !== 1'b0) begin errors++; $display("FAIL conf_grant: got rdy=%b c=%b want 0100 0", eng_ready, conflict); end
      step();
      checks++; if (conflict !== 1'b1 || conflict_lit !== 8'hFA) begin errors++; $display("FAIL conf_flag: got c=%b lit=%h want 1 fa", conflict, conflict_lit); end
      checks++; if (out_valid !== 1'b0 || eng_ready !== 4'b0000) begin errors++; $display("FAIL conf_block: got v=%b rdy=%b want 0 0000", out_valid, eng_ready); end
      checks++; if (n_assigned !== 8'd1) begin errors++; $display("FAIL conf_n: got %0d want 1", n_assigned); end
      step();
      checks++; if (conflict !== 1'b1 || eng_ready !== 4'b0000 || mem_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL conf_hold: got c=%b rdy=%b mr=%b v=%b", conflict, eng_ready, mem_ready, out_valid); end
      eng_valid = 4'b0000;
      do_clear();
      checks++; if (conflict !== 1'b0 || conflict_lit !== 8'h00 || n_assigned !== 8'd0 || mem_ready !== 1'b1) begin errors++; $display("FAIL conf_clear: got c=%b lit=%h n=%0d mr=%b want 0 00 0 1", conflict, conflict_lit, n_assigned, mem_ready); end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_r;
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      out_ready = 1'b1;
      eng_valid = 4'b1111; eng_lit = {8'd13, 8'd12, 8'd11, 8'd10};
      for (int i = 0; i < 8; i++) begin
         #1;
         exp_r = 4'b0001 << (i % 4);
         checks++; if (eng_ready !== exp_r) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", i, eng_ready, exp_r); end
         step();
      end
      eng_valid = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         #1;
         exp_r = (i == 1) ? 4'b1000 : 4'b0010;
         checks++; if (eng_ready !== exp_r) begin errors++; $display("FAIL fair_sparse%0d: got %b want %b", i, eng_ready, exp_r); end
         step();
      end
      eng_valid = 4'b0000;
      step(); step();
      checks++; if (n_assigned !== 8'd4 || out_valid !== 1'b0 || quiescent !== 1'b1) begin errors++; $display("FAIL fair_end: got n=%0d v=%b q=%b want 4 0 1", n_assigned, out_valid, quiescent); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_l;
      out_ready = 1'b0;
      do_clear();
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
      eng_valid = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         eng_lit = 32'd30 + 32'(k);
         #1;
         checks++; if (eng_ready !== 4'b0001) begin errors++; $display("FAIL bp_accept%0d: got %b want 0001", k, eng_ready); end
         step();
      end
      eng_lit = 32'd34;
      #1;
      checks++; if (eng_ready !== 4'b0000) begin errors++; $display("FAIL bp_full0: got %b want 0000", eng_ready); end
      step();
      checks++; if (eng_ready !== 4'b0000 || n_assigned !== 8'd4) begin errors++; $display("FAIL bp_full1: got rdy=%b n=%0d want 0000 4", eng_ready, n_assigned); end
      out_ready = 1'b1;
      #1;
      checks++; if (eng_ready !== 4'b0000 || out_lit !== 8'd30) begin errors++; $display("FAIL bp_pop_full: got rdy=%b lit=%0d want 0000 30", eng_ready, out_lit); end
      step();
      eng_valid = 4'b0000;
      for (int k = 1; k < 4; k++) begin
         #1;
         exp_l = 8'd30 + 8'(k);
         checks++; if (out_valid !== 1'b1 || out_lit !== exp_l) begin errors++; $display("FAIL bp_drain%0d: got v=%b lit=%0d want 1 %0d", k, out_valid, out_lit, exp_l); end
         step();
      end
      checks++; if (out_valid !== 1'b0 || n_assigned !== 8'd4) begin errors++; $display("FAIL bp_empty: got v=%b n=%0d want 0 4", out_valid, n_assigned); end
   endtask

   task automatic test_illegal_reset();
      out_ready = 1'b0;
      do_clear();
      mem_valid = 1'b1; mem_lit = 8'h00;
      #1;
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL ill_zero_ready: got %b want 1", mem_ready); end
      step();
      checks++; if (out_valid !== 1'b0 || n_assigned !== 8'd0) begin errors++; $display("FAIL ill_zero: got v=%b n=%0d want 0 0", out_valid, n_assigned); end
      mem_lit = 8'h80;
      step();
      checks++; if (out_valid !== 1'b0 || n_assigned !== 8'd0) begin errors++; $display("FAIL ill_min: got v=%b n=%0d want 0 0", out_valid, n_assigned); end
      mem_lit = 8'd9; mem_done = 1'b1;
      step();
      mem_valid = 1'b0; mem_done = 1'b0;
      eng_valid = 4'b0010; eng_lit = 32'h0;
      #1;
      checks++; if (eng_ready !== 4'b0010 || out_lit !== 8'd9) begin errors++; $display("FAIL ill_eng_consume: got rdy=%b lit=%h want 0010 09", eng_ready, out_lit); end
      step();
      eng_valid = 4'b0000;
      #1;
      checks++; if (n_assigned !== 8'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL ill_eng_drop: got n=%0d v=%b want 1 1", n_assigned, out_valid); end
      rst = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0 || mem_ready !== 1'b0 || eng_ready !== 4'b0000 || quiescent !== 1'b0) begin errors++; $display("FAIL rst_outputs: got v=%b mr=%b rdy=%b q=%b", out_valid, mem_ready, eng_ready, quiescent); end
      checks++; if (n_assigned !== 8'd0 || conflict !== 1'b0 || conflict_lit !== 8'h00) begin errors++; $display("FAIL rst_regs: got n=%0d c=%b lit=%h", n_assigned, conflict, conflict_lit); end
      rst = 1'b0;
      #1;
      checks++; if (mem_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle: got mr=%b v=%b want 1 0", mem_ready, out_valid); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_dedup();
      test_conflict();
      test_fairness();
      test_back_to_back();
      test_illegal_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
